// File: rtl/pedal_mem_pkg.sv
// ============================================================================
// Module   : pedal_mem_pkg
// Brief    : Shared state encoding, descriptor layout and fixed-point constants
// Revision : 1.0
// ============================================================================
`default_nettype none

package pedal_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_DESC  = 3'd2,
        ST_SAMP  = 3'd3,
        ST_MAC   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int C_DELTA_MSB = 15;
    localparam int C_DELTA_LSB = 9;
    localparam int C_NEG_BIT   = 8;
    localparam int C_MULT_MSB  = 7;
    localparam int C_MULT_LSB  = 0;

    localparam int C_ACC_W   = 32;
    localparam int C_Q_SHIFT = 8;

endpackage

`default_nettype wire

// File: rtl/tap_mac.sv
// ============================================================================
// Module   : tap_mac
// Brief    : Q0.8 tap multiply-accumulate with saturating 16-bit output stage
// Revision : 1.0
// ============================================================================
`default_nettype none

module tap_mac
    import pedal_mem_pkg::*;
#(
    parameter int ACC_W = C_ACC_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [15:0] load_sample_i,
    input  logic        mac_i,
    input  logic [15:0] tap_sample_i,
    input  logic [7:0]  mult_i,
    input  logic        neg_i,
    input  logic        out_en_i,
    output logic [15:0] sample_out_o
);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [15:0]      out_q, out_d;

    logic signed [24:0]      w_samp_ext;
    logic signed [24:0]      w_mult_ext;
    logic signed [24:0]      w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_load_ext;
    logic signed [ACC_W-1:0] w_scaled;
    logic        [ACC_W-16:0] w_hi;
    logic                    w_in_range;

    assign w_samp_ext = {{9{tap_sample_i[15]}}, tap_sample_i};
    assign w_mult_ext = {17'd0, mult_i};
    assign w_prod     = w_samp_ext * w_mult_ext;
    assign w_prod_ext = {{(ACC_W-25){w_prod[24]}}, w_prod};
    assign w_load_ext = {{(ACC_W-16){load_sample_i[15]}}, load_sample_i};

    // In range exactly when every bit above the 16-bit sign bit matches it
    assign w_scaled   = acc_q >>> C_Q_SHIFT;
    assign w_hi       = w_scaled[ACC_W-1:15];
    assign w_in_range = (&w_hi) | ~(|w_hi);

    always_comb begin
        acc_d = acc_q;
        out_d = out_q;
        if (load_i) begin
            acc_d = w_load_ext <<< C_Q_SHIFT;
        end else if (mac_i) begin
            acc_d = neg_i ? (acc_q - w_prod_ext) : (acc_q + w_prod_ext);
        end
        if (out_en_i) begin
            if (w_in_range) begin
                out_d = w_scaled[15:0];
            end else begin
                out_d = w_scaled[ACC_W-1] ? 16'h8000 : 16'h7FFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            out_q <= '0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign sample_out_o = out_q;

endmodule

`default_nettype wire

// File: rtl/reverb_tap_sequencer.sv
// ============================================================================
// Module   : reverb_tap_sequencer
// Brief    : Per-sample circular-buffer write and tap-table walk over shared memory
// Revision : 1.0
// ============================================================================
`default_nettype none

module reverb_tap_sequencer
    import pedal_mem_pkg::*;
#(
    parameter int ACC_W = C_ACC_W,
    parameter int TAP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_tick,
    input  logic [15:0]      sample_in,
    input  logic             enable,
    input  logic [TAP_W-1:0] num_taps,
    input  logic [15:0]      buf_base,
    output logic             mem_req,
    output logic             mem_we,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_ready,
    output logic [15:0]      sample_out,
    output logic             sample_valid,
    output logic             busy,
    output logic             overrun,
    input  logic             overrun_clr
);

    state_t           state_q, state_d;
    logic [15:0]      wr_ptr_q, wr_ptr_d;
    logic [15:0]      base_q, base_d;
    logic [15:0]      tc_q, tc_d;
    logic [TAP_W-1:0] n_q, n_d;
    logic [TAP_W-1:0] k_q, k_d;
    logic [7:0]       mult_q, mult_d;
    logic             neg_q, neg_d;
    logic [15:0]      samp_q, samp_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic             w_xfer;
    logic [15:0]      w_taps_ext;
    logic [TAP_W-1:0] w_n_eff;
    logic [TAP_W:0]   w_k_inc;
    logic [6:0]       w_delta;
    logic [16:0]      w_diff;
    logic [15:0]      w_tc_next;

    assign w_xfer     = req_q & mem_ready;
    assign w_taps_ext = {{(16-TAP_W){1'b0}}, num_taps};
    assign w_n_eff    = (buf_base < w_taps_ext) ? buf_base[TAP_W-1:0] : num_taps;
    assign w_k_inc    = {1'b0, k_q} + 1'b1;

    // Cursor steps back by delta and wraps within [base, FFFF]
    assign w_delta   = mem_rdata[C_DELTA_MSB:C_DELTA_LSB];
    assign w_diff    = {1'b0, tc_q} - {10'd0, w_delta};
    assign w_tc_next = (w_diff[16] || (w_diff[15:0] < base_q))
                     ? (w_diff[15:0] + (16'h0000 - base_q))
                     : w_diff[15:0];

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        base_d    = base_q;
        tc_d      = tc_q;
        n_d       = n_q;
        k_d       = k_q;
        mult_d    = mult_q;
        neg_d     = neg_q;
        samp_d    = samp_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;

        if (sample_tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    base_d = buf_base;
                    n_d    = w_n_eff;
                    k_d    = '0;
                    if (!enable) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WRITE;
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = (wr_ptr_q < buf_base) ? buf_base : wr_ptr_q;
                        wdata_d = sample_in;
                    end
                end
            end
            ST_WRITE: begin
                if (w_xfer) begin
                    tc_d     = addr_q;
                    wr_ptr_d = (addr_q == 16'hFFFF) ? base_q : (addr_q + 16'd1);
                    we_d     = 1'b0;
                    if (n_q == '0) begin
                        state_d = ST_DONE;
                        req_d   = 1'b0;
                    end else begin
                        state_d = ST_DESC;
                        addr_d  = {{(16-TAP_W){1'b0}}, k_q};
                    end
                end
            end
            ST_DESC: begin
                if (w_xfer) begin
                    mult_d  = mem_rdata[C_MULT_MSB:C_MULT_LSB];
                    neg_d   = mem_rdata[C_NEG_BIT];
                    tc_d    = w_tc_next;
                    addr_d  = w_tc_next;
                    state_d = ST_SAMP;
                end
            end
            ST_SAMP: begin
                if (w_xfer) begin
                    samp_d  = mem_rdata;
                    req_d   = 1'b0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                k_d = w_k_inc[TAP_W-1:0];
                if (w_k_inc < {1'b0, n_q}) begin
                    state_d = ST_DESC;
                    req_d   = 1'b1;
                    addr_d  = {{(16-TAP_W){1'b0}}, w_k_inc[TAP_W-1:0]};
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            base_q    <= '0;
            tc_q      <= '0;
            n_q       <= '0;
            k_q       <= '0;
            mult_q    <= '0;
            neg_q     <= 1'b0;
            samp_q    <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            base_q    <= base_d;
            tc_q      <= tc_d;
            n_q       <= n_d;
            k_q       <= k_d;
            mult_q    <= mult_d;
            neg_q     <= neg_d;
            samp_q    <= samp_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    tap_mac #(
        .ACC_W (ACC_W)
    ) u_tap_mac (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_i        ((state_q == ST_IDLE) && sample_tick),
        .load_sample_i (sample_in),
        .mac_i         (state_q == ST_MAC),
        .tap_sample_i  (samp_q),
        .mult_i        (mult_q),
        .neg_i         (neg_q),
        .out_en_i      (state_q == ST_DONE),
        .sample_out_o  (sample_out)
    );

    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != ST_IDLE);
    assign overrun      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_reverb_tap_sequencer.sv
// ============================================================================
// Module   : tb_reverb_tap_sequencer
// Brief    : Directed self-checking bench with a wait-state memory model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reverb_tap_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic [15:0] sample_in = '0;
    logic        enable = 1'b0;
    logic [7:0]  num_taps = '0;
    logic [15:0] buf_base = '0;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [15:0] sample_out;
    logic        sample_valid, busy, overrun;
    logic        overrun_clr = 1'b0;

    reverb_tap_sequencer #(.ACC_W(32), .TAP_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .sample_in(sample_in),
        .enable(enable), .num_taps(num_taps), .buf_base(buf_base),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .sample_out(sample_out),
        .sample_valid(sample_valid), .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int t0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: responds after wait_cycles stall cycles, logs traffic
    logic [15:0] mem [0:65535];
    int          wait_cycles = 0;
    int          wait_cnt = 0;
    int          req_cnt = 0;
    logic [15:0] wr_log [$];
    logic [15:0] last_rd = '0;
    logic        pend = 1'b0;
    logic [33:0] held = '0;

    always @(negedge clk) begin
        if (pend && rst_n) begin
            n_total++;
            if ({mem_req, mem_we, mem_addr, mem_wdata} !== held)
                $display("FAIL hold_stable: got %h required %h", {mem_req, mem_we, mem_addr, mem_wdata}, held);
            else n_pass++;
        end
        pend = 1'b0;
        if (mem_req === 1'b1) begin
            req_cnt++;
            if (wait_cnt >= wait_cycles) begin
                mem_ready = 1'b1;
                wait_cnt  = 0;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    wr_log.push_back(mem_addr);
                    mem_rdata = 16'h0000;
                end else begin
                    mem_rdata = mem[mem_addr];
                    last_rd   = mem_addr;
                end
            end else begin
                mem_ready = 1'b0;
                wait_cnt++;
                pend = 1'b1;
                held = {mem_req, mem_we, mem_addr, mem_wdata};
            end
        end else begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; sample_tick = 1'b0; overrun_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wr_log.delete();
    endtask

    task automatic do_tick(input logic [15:0] s, input logic en, input logic [7:0] nt, input logic [15:0] base);
        @(negedge clk);
        sample_in = s; enable = en; num_taps = nt; buf_base = base;
        sample_tick = 1'b1; t0 = cyc;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            if (sample_valid === 1'b1) begin lat = cyc - t0; break; end
            @(negedge clk);
        end
        if (lat < 0) begin
            n_total++;
            $display("FAIL %s_timeout: no sample_valid within 400 cycles", name);
        end
    endtask

    task automatic frame(input string name, input logic [15:0] s, input logic en, input logic [7:0] nt,
                         input logic [15:0] base, output int lat);
        do_tick(s, en, nt, base);
        wait_valid(name, lat);
    endtask

    task automatic test_reset();
        int lat;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if ({mem_req, mem_we, sample_valid, busy, overrun} !== 5'b0)
            $display("FAIL reset_flags: got %b required 00000", {mem_req, mem_we, sample_valid, busy, overrun}); else n_pass++;
        n_total++; if ({mem_addr, mem_wdata, sample_out} !== 48'h0)
            $display("FAIL reset_data: got %h required 0", {mem_addr, mem_wdata, sample_out}); else n_pass++;
        rst_n = 1'b1;
        lat = 0;
    endtask

    task automatic test_taps_zero();
        int lat;
        do_reset(); wait_cycles = 0;
        frame("t0a", 16'd100, 1'b1, 8'd0, 16'd4, lat);
        n_total++; if (lat !== 3) $display("FAIL t0a_latency: got %0d required 3", lat); else n_pass++;
        n_total++; if (sample_out !== 16'd100) $display("FAIL t0a_out: got %0d required 100", $signed(sample_out)); else n_pass++;
        frame("t0b", 16'hFF38, 1'b1, 8'd0, 16'd4, lat);
        n_total++; if (lat !== 3) $display("FAIL t0b_latency: got %0d required 3", lat); else n_pass++;
        n_total++; if (sample_out !== 16'hFF38) $display("FAIL t0b_out: got %0d required -200", $signed(sample_out)); else n_pass++;
        n_total++; if (wr_log.size() !== 2) $display("FAIL t0_wr_count: got %0d required 2", wr_log.size());
        else if (wr_log[0] !== 16'd4 || wr_log[1] !== 16'd5)
            $display("FAIL t0_wr_addr: got %h,%h required 0004,0005", wr_log[0], wr_log[1]);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int lat;
        do_reset(); wait_cycles = 0;
        mem[0] = 16'h0280;  // delta 1, add, mult 128
        frame("wr1", 16'd10, 1'b1, 8'd0, 16'hFFFE, lat);
        frame("wr2", 16'd20, 1'b1, 8'd0, 16'hFFFE, lat);
        frame("wr3", 16'd30, 1'b1, 8'd1, 16'hFFFE, lat);
        n_total++; if (wr_log.size() !== 3) $display("FAIL wrap_wr_count: got %0d required 3", wr_log.size());
        else if (wr_log[0] !== 16'hFFFE || wr_log[1] !== 16'hFFFF || wr_log[2] !== 16'hFFFE)
            $display("FAIL wrap_wr_addr: got %h,%h,%h required FFFE,FFFF,FFFE", wr_log[0], wr_log[1], wr_log[2]);
        else n_pass++;
        n_total++; if (last_rd !== 16'hFFFF) $display("FAIL wrap_tap_addr: got %h required FFFF", last_rd); else n_pass++;
        n_total++; if (sample_out !== 16'd40) $display("FAIL wrap_out: got %0d required 40", $signed(sample_out)); else n_pass++;
        n_total++; if (lat !== 6) $display("FAIL wrap_latency: got %0d required 6", lat); else n_pass++;
    endtask

    task automatic test_single_tap();
        int lat;
        do_reset(); wait_cycles = 0;
        mem[0] = 16'h0280;
        frame("st1", 16'd1000, 1'b1, 8'd0, 16'd4, lat);
        frame("st2", 16'd2000, 1'b1, 8'd1, 16'd4, lat);
        n_total++; if (sample_out !== 16'd2500) $display("FAIL single_add: got %0d required 2500", $signed(sample_out)); else n_pass++;
        n_total++; if (lat !== 6) $display("FAIL single_latency: got %0d required 6", lat); else n_pass++;
        mem[0] = 16'h0380;  // same tap, subtract
        frame("st3", 16'd1000, 1'b1, 8'd0, 16'd4, lat);
        frame("st4", 16'd2000, 1'b1, 8'd1, 16'd4, lat);
        n_total++; if (sample_out !== 16'd1500) $display("FAIL single_neg: got %0d required 1500", $signed(sample_out)); else n_pass++;
    endtask

    task automatic test_saturation();
        int lat;
        do_reset(); wait_cycles = 0;
        mem[0] = 16'h02FF;  // delta 1, mult 255
        mem[1] = 16'h00FF;  // delta 0 re-reads the same cursor
        frame("sp1", 16'h7FFF, 1'b1, 8'd0, 16'd4, lat);
        frame("sp2", 16'h7FFF, 1'b1, 8'd2, 16'd4, lat);
        n_total++; if (sample_out !== 16'h7FFF) $display("FAIL sat_pos: got %0d required 32767", $signed(sample_out)); else n_pass++;
        n_total++; if (lat !== 9) $display("FAIL sat_latency: got %0d required 9", lat); else n_pass++;
        frame("sn1", 16'h8000, 1'b1, 8'd0, 16'd4, lat);
        frame("sn2", 16'h8000, 1'b1, 8'd2, 16'd4, lat);
        n_total++; if (sample_out !== 16'h8000) $display("FAIL sat_neg: got %0d required -32768", $signed(sample_out)); else n_pass++;
    endtask

    task automatic test_overrun_wait();
        int lat;
        do_reset(); wait_cycles = 5;
        mem[0] = 16'h0280;
        frame("ow1", 16'd1000, 1'b1, 8'd0, 16'd4, lat);
        n_total++; if (lat !== 8) $display("FAIL ow1_latency: got %0d required 8", lat); else n_pass++;
        do_tick(16'd2000, 1'b1, 8'd1, 16'd4);
        repeat (3) @(negedge clk);
        sample_in = 16'd999; num_taps = 8'd0; sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        n_total++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %b required 1", overrun); else n_pass++;
        wait_valid("ow2", lat);
        n_total++; if (sample_out !== 16'd2500) $display("FAIL ow2_out: got %0d required 2500", $signed(sample_out)); else n_pass++;
        n_total++; if (lat !== 21) $display("FAIL ow2_latency: got %0d required 21", lat); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL ow2_busy: got %b required 0", busy); else n_pass++;
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        n_total++; if (overrun !== 1'b0) $display("FAIL overrun_clr: got %b required 0", overrun); else n_pass++;
        do_tick(16'd3000, 1'b1, 8'd0, 16'd4);
        @(negedge clk);
        sample_tick = 1'b1; overrun_clr = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0; overrun_clr = 1'b0;
        n_total++; if (overrun !== 1'b1) $display("FAIL overrun_set_clr: got %b required 1", overrun); else n_pass++;
        wait_valid("ow3", lat);
        n_total++; if (sample_out !== 16'd3000) $display("FAIL ow3_out: got %0d required 3000", $signed(sample_out)); else n_pass++;
        n_total++; if (wr_log.size() !== 3) $display("FAIL ow_wr_count: got %0d required 3", wr_log.size());
        else if (wr_log[2] !== 16'd6) $display("FAIL ow_wr_addr: got %h required 0006", wr_log[2]);
        else n_pass++;
        wait_cycles = 0;
    endtask

    task automatic test_reset_bypass();
        int lat;
        int rc;
        do_reset(); wait_cycles = 0;
        mem[0] = 16'h0280;
        frame("rb1", 16'd1000, 1'b1, 8'd0, 16'd4, lat);
        do_tick(16'd2000, 1'b1, 8'd1, 16'd4);
        repeat (2) @(negedge clk);
        n_total++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'd4})
            $display("FAIL samp_req: got %b/%b/%h required 1/0/0004", mem_req, mem_we, mem_addr); else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        n_total++; if ({mem_req, mem_we, sample_valid, busy, overrun} !== 5'b0)
            $display("FAIL midreset_flags: got %b required 00000", {mem_req, mem_we, sample_valid, busy, overrun}); else n_pass++;
        n_total++; if ({mem_addr, mem_wdata, sample_out} !== 48'h0)
            $display("FAIL midreset_data: got %h required 0", {mem_addr, mem_wdata, sample_out}); else n_pass++;
        rst_n = 1'b1;
        rc = req_cnt;
        frame("byp", 16'd77, 1'b0, 8'd1, 16'd4, lat);
        n_total++; if (sample_out !== 16'd77) $display("FAIL bypass_out: got %0d required 77", $signed(sample_out)); else n_pass++;
        n_total++; if (lat !== 2) $display("FAIL bypass_latency: got %0d required 2", lat); else n_pass++;
        n_total++; if (req_cnt !== rc) $display("FAIL bypass_noreq: got %0d requests required 0", req_cnt - rc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_taps_zero();
        test_wrap();
        test_single_tap();
        test_saturation();
        test_overrun_wait();
        test_reset_bypass();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/reverb_tap_sequencer.md
# reverb_tap_sequencer

Sequences all accesses to the shared 16-bit sample/impulse memory, on-chip SRAM or off-chip, once per ADC sample period. On each sample tick it writes the incoming sample into a circular buffer. It then walks a tap descriptor table, fetching one delayed sample per tap, and accumulates the weighted sum into one wet/dry output sample. It sits between the ADC front end, the memory port and the DAC path, and is the only master on the memory port.

## Interface
Parameters:
- `ACC_W`, 32: accumulator width; must be ≥ 32.
- `TAP_W`, 8: width of the tap count. The maximum tap count is 255.

Ports:
- `clk`  in  1: system clock. All logic is on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `sample_tick`  in  1: one-cycle strobe meaning a new `sample_in` is valid.
- `sample_in`  in  16: signed ADC sample.
- `enable`  in  1: 0 = bypass, with no memory traffic.
- `num_taps`  in  8: number of descriptors to process.
- `buf_base`  in  16: first circular-buffer address. It is also the descriptor table size; the table occupies addresses 0..`buf_base`-1.
- `mem_req`  out  1: memory transaction request.
- `mem_we`  out  1: 1 = write, 0 = read.
- `mem_addr`  out  16: transaction address.
- `mem_wdata`  out  16: write data.
- `mem_rdata`  in  16: read data, valid in the cycle `mem_ready`=1.
- `mem_ready`  in  1: transaction accept/complete.
- `sample_out`  out  16: signed processed sample.
- `sample_valid`  out  1: one-cycle pulse when `sample_out` updates.
- `busy`  out  1: a frame is in progress.
- `overrun`  out  1: sticky flag; a tick arrived while `busy`.
- `overrun_clr`  in  1: clears `overrun`.

## Operation
- Reset values:
  - `mem_req`, `mem_we`, `sample_valid`, `busy` and `overrun` are 0.
  - `mem_addr`, `mem_wdata` and `sample_out` are 0.
  - The write pointer `wr_ptr` is 0.
  - The state is IDLE.
- IDLE, on `sample_tick`:
  - Latch `sample_in`, `enable`, `num_taps` and `buf_base`.
  - Effective taps N = min(`num_taps`, `buf_base`).
  - With enable=0, go to DONE with acc = `sample_in`<<<8.
  - Otherwise go to WRITE.
- WRITE:
  - Write address wa = (`wr_ptr` < base) ? base : `wr_ptr`.
  - Write `sample_in` to wa.
  - Initialise acc = sign-extended `sample_in`<<<8; this is the dry path at unity gain.
  - Tap cursor tc = wa.
  - Advance `wr_ptr` = (wa == 16'hFFFF) ? base : wa+1.
  - Go to DESC, or to DONE if N == 0.
- DESC (tap k):
  - Read address k.
  - Descriptor fields: [15:9] delta (unsigned 7 bits), [8] neg, [7:0] mult (unsigned Q0.8).
  - Compute the new tap cursor with wrap: if tc − delta < base (17-bit compare), then tc = tc − delta + (2^16 − base); else tc = tc − delta.
  - Delta 0 is legal and re-reads the previous cursor.
- SAMP: read address tc and go to MAC.
- MAC:
  - p = sample × {1'b0, mult}, a signed 25-bit product.
  - acc = neg ? acc − p : acc + p.
  - Then k++ and go to DESC if k < N, else to DONE.
- DONE:
  - `sample_out` = saturate(acc >>> 8) to the range [−32768, 32767].
  - `sample_valid` pulses.
  - Return to IDLE.
- Memory handshake:
  - Hold `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stable until a cycle with `mem_req` & `mem_ready`.
  - Capture `mem_rdata` in that cycle.
  - Drop `mem_req` or present the next transaction on the following edge; back-to-back requests are allowed.
  - `mem_we` is 1 only in WRITE.
- `busy` is 1 in every state except IDLE.
- Overrun:
  - A `sample_tick` while `busy` is dropped, and the frame in progress completes unchanged.
  - `overrun` is set on the next edge.
  - `overrun_clr` clears it. A simultaneous set and clear leaves it set.
- Reset mid-frame: everything returns to reset values on the next edge, and a pending memory request is abandoned.
- Accumulator range: with 255 taps at the worst case, |acc| < 2^31, so no internal overflow is possible at `ACC_W`=32.

## Timing
- With zero-wait memory (`mem_ready`=1):
  - Tick at cycle 0.
  - WRITE request at cycle 1.
  - Tap k DESC at cycle 2+3k, SAMP at 3+3k, MAC at 4+3k.
  - DONE at 2+3N.
  - `sample_valid` at cycle 3+3N.
- Each memory wait cycle adds exactly one cycle of latency.
- Bypass: `sample_valid` at cycle 2; no `mem_req` is issued.
- The next tick is accepted in the first cycle the block is back in IDLE.

## Structure
- Shared package `pedal_mem_pkg` holds:
  - the state enum (IDLE, WRITE, DESC, SAMP, MAC, DONE);
  - descriptor field bit positions;
  - `ACC_W` and the Q0.8 shift constant.
- Sub-module `tap_mac` holds the multiply, the signed add/sub, the accumulator register and the output saturation.
- The FSM, pointers and memory port live in the top level.

## Test plan
- Taps and wrap:
  - Stimulus: base=4, num_taps=0, ticks with 100, −200, `mem_ready`=1.
  - Writes go to addresses 4 and 5.
  - `sample_out` = 100 and −200.
  - `sample_valid` arrives 3 cycles after each tick.
- Wrap:
  - Stimulus: base=16'hFFFE, three ticks.
  - Writes go to FFFE, FFFF, then FFFE.
  - A tap with delta=1 after the third write reads FFFF.
- Single tap:
  - Stimulus: descriptor 0 = {delta 1, neg 0, mult 128}; previous sample 1000; current sample 2000.
  - `sample_out` = 2500.
  - With neg=1, `sample_out` = 1500.
- Saturation:
  - Stimulus: two taps with mult=255 on samples of 32767.
  - `sample_out` = 32767.
  - Negated, `sample_out` = −32768.
- Overrun and wait states:
  - `mem_ready` low for 5 cycles per access.
  - A second tick mid-frame sets `overrun`, and the frame still completes with correct data.
  - `overrun_clr` clears the flag.
  - Checker: the request is held stable while waiting.
- Reset and bypass:
  - Assert `rst_n`=0 during SAMP; all outputs are 0 next cycle and `mem_req` drops.
  - Then tick with enable=0, sample 77: `sample_out` = 77 at cycle 2, with no `mem_req`.
